// File: rtl/cmul_pkg.sv
// Shared constants and types for the arbitrated shift-add constant multiplier.
// Build option: CMUL_NEG_EN enables per-request negation of the product.
package cmul_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int IN_W  = 16;
  localparam int OUT_W = 24;

  localparam int COEF_0 = 83;
  localparam int COEF_1 = 36;
  localparam int COEF_2 = 64;
  localparam int COEF_3 = 89;

  typedef logic [1:0] coef_sel_t;

  localparam coef_sel_t SEL_83 = 2'd0;
  localparam coef_sel_t SEL_36 = 2'd1;
  localparam coef_sel_t SEL_64 = 2'd2;
  localparam coef_sel_t SEL_89 = 2'd3;

endpackage

// File: rtl/cmul_shiftadd.sv
// Two-stage shift-add constant multiplier: stage 1 forms two partial sums,
// stage 2 adds them and, when CMUL_NEG_EN is defined, optionally negates.
module cmul_shiftadd
  import cmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  op,
  input  coef_sel_t        sel,
  input  logic             neg,
  output logic [OUT_W-1:0] product
);

  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] hi_next, lo_next;
  logic [OUT_W-1:0] hi_reg, lo_reg;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] product_next;
  logic [OUT_W-1:0] product_reg;

  assign x = {{(OUT_W-IN_W){1'b0}}, op};

  // 83 = 64+16+2+1, 36 = 32+4, 64 = 64, 89 = 64+16+8+1
  always_comb begin
    hi_next = '0;
    lo_next = '0;
    unique case (sel)
      SEL_83: begin
        hi_next = (x << 6) + (x << 4);
        lo_next = (x << 1) + x;
      end
      SEL_36: begin
        hi_next = x << 5;
        lo_next = x << 2;
      end
      SEL_64: begin
        hi_next = x << 6;
        lo_next = '0;
      end
      SEL_89: begin
        hi_next = (x << 6) + (x << 4);
        lo_next = (x << 3) + x;
      end
      default: begin
        hi_next = '0;
        lo_next = '0;
      end
    endcase
  end

  assign sum = hi_reg + lo_reg;

`ifdef CMUL_NEG_EN
  logic neg_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_reg <= 1'b0;
    end else if (en) begin
      neg_reg <= neg;
    end
  end

  assign product_next = neg_reg ? (~sum + 1'b1) : sum;
`else
  logic unused_neg;
  assign unused_neg   = neg;
  assign product_next = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      product_reg <= '0;
    end else if (en) begin
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      product_reg <= product_next;
    end
  end

  assign product = product_reg;

endmodule

// File: rtl/cmul_arb.sv
// Four-requester round-robin front end sharing one cmul_shiftadd pipeline.
// Build option: CMUL_NEG_EN (req_neg honoured only when defined).
module cmul_arb
  import cmul_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*IN_W-1:0]  req_data,
  input  logic [N_REQ*2-1:0]     req_coef,
  input  logic [N_REQ-1:0]       req_neg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id
);

  logic [ID_W-1:0] ptr_reg;
  logic            s1_valid_reg;
  logic [ID_W-1:0] s1_id_reg;
  logic            out_valid_reg;
  logic [ID_W-1:0] out_id_reg;

  logic            advance;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic            hs;

  logic [IN_W-1:0] lane_data [N_REQ];
  coef_sel_t       lane_sel  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*IN_W +: IN_W];
      assign lane_sel[gi]  = req_coef[gi*2 +: 2];
      assign req_ready[gi] = hs && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance = !out_valid_reg || out_ready;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_id  = ptr_reg;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr_reg + ID_W'(k);
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign hs = grant_any && advance && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_id_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
    end else begin
      if (hs) begin
        ptr_reg <= grant_id + 1'b1;
      end
      if (advance) begin
        s1_valid_reg  <= hs;
        s1_id_reg     <= grant_id;
        out_valid_reg <= s1_valid_reg;
        out_id_reg    <= s1_id_reg;
      end
    end
  end

  cmul_shiftadd u_shiftadd (
    .clk     (clk),
    .rst     (rst),
    .en      (advance),
    .op      (lane_data[grant_id]),
    .sel     (lane_sel[grant_id]),
    .neg     (req_neg[grant_id]),
    .product (out_data)
  );

  assign out_valid = out_valid_reg;
  assign out_id    = out_id_reg;

endmodule

// File: tb/tb_cmul_arb.sv
// Directed bench for cmul_arb: single requests, negate, boundary operand,
// round-robin order, backpressure and reset with results in flight.
module tb_cmul_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [7:0]  req_coef;
  logic [3:0]  req_neg;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [1:0]  out_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmul_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_coef  (req_coef),
    .req_neg   (req_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] d, input logic [1:0] s, input logic n);
    req_data[16*i +: 16] = d;
    req_coef[2*i +: 2]   = s;
    req_neg[i]           = n;
  endtask

  // One isolated request on an idle pipe, out_ready held high.
  task automatic single(input string tag, input int idx, input logic [15:0] d,
                        input logic [1:0] s, input logic n, input logic [23:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(negedge clk);
    set_lane(idx, d, s, n);
    req_valid = oh;
    #1;
    check({tag, "_rdy"}, {28'd0, req_ready}, {28'd0, oh});
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    check({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {8'd0, out_data}, {8'd0, exp});
    check({tag, "_id"}, {30'd0, out_id}, idx);
    $display("txn %s id=%0d data=0x%06h", tag, out_id, out_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rr_rdy [5];
    logic [1:0]  rr_id  [5];
    logic [23:0] rr_dat [5];
    logic [23:0] neg_exp;

    rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_dat = '{24'h000053, 24'h000048, 24'h0000C0, 24'h000164, 24'h000053};
`ifdef CMUL_NEG_EN
    neg_exp = 24'hFFFFAD;
`else
    neg_exp = 24'h000053;
`endif

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = '0;
    req_coef  = '0;
    req_neg   = '0;
    out_ready = 1'b1;

    // Reset state and combinational ready suppression.
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_rdy_comb", {28'd0, req_ready}, 32'd0);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_data", {8'd0, out_data}, 32'd0);
    check("rst_id", {30'd0, out_id}, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    single("single_r2", 2, 16'h0001, 2'd0, 1'b0, 24'h000053);
    single("negate_r1", 1, 16'h0001, 2'd0, 1'b1, neg_exp);
    single("max_r0",    0, 16'hFFFF, 2'd3, 1'b0, 24'h58FFA7);
    single("sel1_r3",   3, 16'h1234, 2'd1, 1'b0, 24'h028F50);
    single("sel2_r1",   1, 16'hABCD, 2'd2, 1'b0, 24'h2AF340);

    // Round-robin from a fresh reset with all requesters valid.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 16'(i + 1), 2'(i), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) check($sformatf("rr_rdy%0d", c), {28'd0, req_ready}, {28'd0, rr_rdy[c]});
      if (c >= 2) begin
        check($sformatf("rr_vld%0d", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("rr_id%0d", c), {30'd0, out_id}, {30'd0, rr_id[c-2]});
        check($sformatf("rr_data%0d", c), {8'd0, out_data}, {8'd0, rr_dat[c-2]});
        $display("txn rr id=%0d data=0x%06h", out_id, out_data);
      end
    end

    // Backpressure: pointer is at 1, stall three cycles holding id 1.
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("bp_rdy0", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    #1;
    check("bp_rdy1", {28'd0, req_ready}, 32'b0100);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check($sformatf("bp_stall_rdy%0d", c), {28'd0, req_ready}, 32'd0);
      check($sformatf("bp_stall_vld%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_stall_id%0d", c), {30'd0, out_id}, 32'd1);
      check($sformatf("bp_stall_data%0d", c), {8'd0, out_data}, 32'h48);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", {28'd0, req_ready}, 32'b1000);
    check("bp_rel_id", {30'd0, out_id}, 32'd1);
    check("bp_rel_data", {8'd0, out_data}, 32'h48);
    $display("txn bp id=%0d data=0x%06h", out_id, out_data);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("bp_nx_vld", {31'd0, out_valid}, 32'd1);
    check("bp_nx_id", {30'd0, out_id}, 32'd2);
    check("bp_nx_data", {8'd0, out_data}, 32'hC0);
    $display("txn bp id=%0d data=0x%06h", out_id, out_data);
    @(negedge clk);
    #1;
    check("bp_last_vld", {31'd0, out_valid}, 32'd1);
    check("bp_last_id", {30'd0, out_id}, 32'd3);
    check("bp_last_data", {8'd0, out_data}, 32'h164);
    $display("txn bp id=%0d data=0x%06h", out_id, out_data);
    @(negedge clk);
    #1;
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with two results in flight; pointer would otherwise sit at 2.
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("mr_rdy0", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    #1;
    check("mr_rdy1", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_inflight_vld", {31'd0, out_valid}, 32'd1);
    check("mr_rst_rdy", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_post_vld", {31'd0, out_valid}, 32'd0);
    check("mr_post_data", {8'd0, out_data}, 32'd0);
    check("mr_post_id", {30'd0, out_id}, 32'd0);
    check("mr_ptr0_rdy", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("mr_no_stale", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("mr_new_vld", {31'd0, out_valid}, 32'd1);
    check("mr_new_id", {30'd0, out_id}, 32'd0);
    check("mr_new_data", {8'd0, out_data}, 32'h53);
    $display("txn mr id=%0d data=0x%06h", out_id, out_data);
    @(negedge clk);
    #1;
    check("mr_end_vld", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
